// File: rtl/demux_rr_dispatch.sv
// rtl/demux_rr_dispatch.sv - round-robin dispatch stage feeding the 1-to-4 demux; optional DEMUX_DISPATCH_CNT_EN accept counters
module demux_rr_dispatch #(
    parameter int width = 8,
    parameter int snum  = 2,
    localparam int NCH  = 1 << snum
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH-1:0]       ch_ready,
    output logic [width-1:0]     out_data,
    output logic [snum-1:0]      out_sel,
    output logic                 out_valid,
    output logic [NCH*8-1:0]     ch_cnt
);

    logic [snum-1:0] ptr;
    logic [snum-1:0] pick;
    logic [snum-1:0] cand;
    logic            found;
    logic            accept;
    logic            load;

    assign accept   = out_valid & ch_ready[out_sel];
    assign in_ready = ~out_valid | accept;
    assign load     = in_valid & in_ready;

    // First ready channel at or after ptr (wrapping); fall back to ptr when none is ready
    always_comb begin
        pick  = ptr;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cand = ptr + snum'(i);
            if (!found && ch_ready[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Output word register: load on handshake, clear valid when drained, otherwise hold the choice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sel   <= pick;
            ptr       <= pick + 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [7:0] cnt [NCH];

    // Per-channel saturating count of accepted words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) cnt[k] <= '0;
        end else if (accept && cnt[out_sel] != 8'hFF) begin
            cnt[out_sel] <= cnt[out_sel] + 8'd1;
        end
    end

    // Flatten the counters onto the output bus, channel k in bits [8k+7:8k]
    always_comb begin
        ch_cnt = '0;
        for (int k = 0; k < NCH; k++) ch_cnt[8*k +: 8] = cnt[k];
    end
`else
    assign ch_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// tb/tb_demux_rr_dispatch.sv - scoreboard bench for demux_rr_dispatch with a behavioural channel-choice model
module tb_demux_rr_dispatch;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NCH-1:0]   ch_ready = '0;
    logic [7:0]       out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic [NCH*8-1:0] ch_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state (next-cycle view after each step)
    int          m_ptr = 0;
    bit          m_valid = 0;
    int          m_sel = 0;
    int          m_data = 0;
    int          m_cnt [NCH];
    logic [9:0]  exp_q [$];

    demux_rr_dispatch #(.width(8), .snum(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ch_ready(ch_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .ch_cnt(ch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_sel = 0; m_data = 0;
        for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, check the visible state against the model, then advance the model
    task automatic step(input bit v, input logic [7:0] d, input logic [NCH-1:0] r);
        bit acc;
        bit ld;
        int choice;
        @(negedge clk);
        in_valid = v; in_data = d; ch_ready = r;
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
            chk("hold_sel", int'(out_sel), m_sel);
            chk("hold_data", int'(out_data), m_data);
        end
        acc = m_valid && r[m_sel];
        chk("in_ready", int'(in_ready), int'(!m_valid || acc));
        ld = v && (!m_valid || acc);
        if (acc) begin
            if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
            m_valid = 0;
        end
        if (ld) begin
            choice = m_ptr;
            for (int i = NCH - 1; i >= 0; i--)
                if (r[(m_ptr + i) % NCH]) choice = (m_ptr + i) % NCH;
            m_sel = choice; m_data = d; m_valid = 1;
            m_ptr = (choice + 1) % NCH;
            exp_q.push_back({choice[1:0], d});
        end
    endtask

    task automatic check_counters(input string name);
        for (int k = 0; k < NCH; k++) begin
`ifdef DEMUX_DISPATCH_CNT_EN
            chk(name, int'(ch_cnt[8*k +: 8]), m_cnt[k]);
`else
            chk(name, int'(ch_cnt[8*k +: 8]), 0);
`endif
        end
    endtask

    // Monitor: every DUT accept must match the oldest pushed expectation
    always @(negedge clk) begin
        logic [9:0] e;
        #2;
        if (rst_n && out_valid && ch_ready[out_sel]) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL accept_unexpected actual=%0h/%0d expected=none", out_data, out_sel);
            end else begin
                e = exp_q.pop_front();
                chk("acc_data", int'(out_data), int'(e[7:0]));
                chk("acc_sel", int'(out_sel), int'(e[9:8]));
            end
        end
    end

    initial begin
        logic [7:0] seq [5];
        seq[0] = 8'hA0; seq[1] = 8'hB0; seq[2] = 8'hC0; seq[3] = 8'hD0; seq[4] = 8'hE0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sel", int'(out_sel), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        check_counters("reset_cnt");

        // Only channel 2 ready from ptr=0
        step(1, 8'hA5, 4'b0100);
        step(0, 8'h00, 4'b0100);
        chk("t3_sel", int'(out_sel), 2);
        chk("t3_data", int'(out_data), 8'hA5);
        step(1, 8'h11, 4'b1111);
        step(0, 8'h00, 4'b1111);
        chk("t3_next_sel", int'(out_sel), 3);

        // Back-to-back with all channels ready
        for (int i = 0; i < 5; i++) step(1, seq[i], 4'b1111);
        step(0, 8'h00, 4'b1111);

        // No channel ready: hold, then same-cycle drain and reload
        step(1, 8'h3C, 4'b0000);
        for (int i = 0; i < 3; i++) step(1, 8'h99, 4'b0000);
        step(1, 8'h4D, 4'b0001 << m_sel);
        step(0, 8'h00, 4'b1111);
        step(0, 8'h00, 4'b1111);

        // Wrap from ptr=3 and ignore late readiness on another channel
        step(1, 8'h21, 4'b0100);
        step(0, 8'h00, 4'b0100);
        step(1, 8'h5A, 4'b0011);
        step(0, 8'h00, 4'b0000);
        chk("t5_wrap_sel", int'(out_sel), 0);
        step(0, 8'h00, 4'b0100);
        chk("t5_no_revise", int'(out_sel), 0);
        step(0, 8'h00, 4'b0001);
        check_counters("mid_cnt");

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 8'($urandom), 4'($urandom));
        for (int i = 0; i < 3; i++) step(0, 8'h00, 4'b1111);
        check_counters("rand_cnt");

        // Saturation on channel 1
        for (int i = 0; i < 300; i++) step(1, 8'(i), 4'b0010);
        step(0, 8'h00, 4'b0010);
        step(0, 8'h00, 4'b0010);
        check_counters("sat_cnt");
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("sat_ch1", int'(ch_cnt[15:8]), 8'hFF);
`else
        chk("sat_ch1", int'(ch_cnt[15:8]), 8'h00);
`endif
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset while holding a word
        step(1, 8'h77, 4'b0000);
        step(0, 8'h00, 4'b0000);
        chk("pre_reset_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_sel", int'(out_sel), 0);
        chk("async_cnt", int'(ch_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);
        step(1, 8'h42, 4'b1000);
        step(0, 8'h00, 4'b1000);
        step(0, 8'h00, 4'b0000);
        check_counters("post_reset_cnt");
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
